mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 512x16 program/data memory between the CPU (port 0: fetch, LDI operand and ALU-immediate reads) and a program loader/debug master (port 1: bulk writes and readback). Each cycle it grants at most one request using round-robin with a bounded lock for bursts, drives the memory's synchronous port, and returns read data with a registered valid. It sits between the CPU/loader and the memory array, and lets a program be loaded while the CPU is running.

---
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the memory-side port of mem_arbiter.
// The arbiter uses the slave modport; requesters and the memory use master.
interface mem_arbiter_if #(
    parameter int AW = 9,
    parameter int DW = 16
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic          lock0;
    logic          lock1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1,
        input  addr0, addr1, wdata0, wdata1,
        input  mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1,
        output addr0, addr1, wdata0, wdata1,
        output mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing one synchronous
// single-port memory between the CPU (port 0) and the loader (port 1).
module mem_arbiter #(
    parameter int AW       = 9,
    parameter int DW       = 16,
    parameter int LOCK_MAX = 8
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(LOCK_MAX + 1);

    logic          r_last;
    logic          r_owner;
    logic          r_owned;
    logic [CW-1:0] r_lockCnt;
    logic          r_rv0;
    logic          r_rv1;

    logic [1:0]    w_req;
    logic [1:0]    w_we;
    logic [1:0]    w_lock;
    logic          w_keep;
    logic          w_expired;
    logic          w_gntAny;
    logic          w_gntSel;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_grant;

    assign w_req  = {bus.req1, bus.req0};
    assign w_we   = {bus.we1, bus.we0};
    assign w_lock = {bus.lock1, bus.lock0};

    // A live lock keeps the owner; once its budget is spent the waiting port wins.
    always_comb begin
        w_keep    = r_owned & w_req[r_owner] & (r_lockCnt < CW'(LOCK_MAX));
        w_expired = r_owned & w_req[r_owner] & ~w_keep;
        w_gntAny  = 1'b0;
        w_gntSel  = 1'b0;
        if (w_keep) begin
            w_gntAny = 1'b1;
            w_gntSel = r_owner;
        end else if (w_req[0] && w_req[1]) begin
            w_gntAny = 1'b1;
            w_gntSel = w_expired ? ~r_owner : ~r_last;
        end else if (w_req[0]) begin
            w_gntAny = 1'b1;
            w_gntSel = 1'b0;
        end else if (w_req[1]) begin
            w_gntAny = 1'b1;
            w_gntSel = 1'b1;
        end
    end

    // Grants are gated by rst_n so nothing reaches the memory during reset.
    assign w_gnt0  = rst_n & w_gntAny & ~w_gntSel;
    assign w_gnt1  = rst_n & w_gntAny & w_gntSel;
    assign w_grant = w_gnt0 | w_gnt1;

    assign bus.gnt0      = w_gnt0;
    assign bus.gnt1      = w_gnt1;
    assign bus.mem_en    = w_grant;
    assign bus.mem_we    = w_grant & w_we[w_gntSel];
    assign bus.mem_addr  = !w_grant ? '0 : (w_gntSel ? bus.addr1 : bus.addr0);
    assign bus.mem_wdata = !w_grant ? '0 : (w_gntSel ? bus.wdata1 : bus.wdata0);
    assign bus.rvalid0   = r_rv0;
    assign bus.rvalid1   = r_rv1;
    assign bus.rdata     = bus.mem_rdata;

    // The lock budget only drains while the other port is actually waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last    <= 1'b1;
            r_owner   <= 1'b0;
            r_owned   <= 1'b0;
            r_lockCnt <= '0;
            r_rv0     <= 1'b0;
            r_rv1     <= 1'b0;
        end else begin
            r_rv0 <= w_gnt0 & ~w_we[0];
            r_rv1 <= w_gnt1 & ~w_we[1];
            if (w_grant) begin
                r_last <= w_gntSel;
                if (w_lock[w_gntSel]) begin
                    r_owned <= 1'b1;
                    r_owner <= w_gntSel;
                    if (r_owned && (r_owner == w_gntSel)) begin
                        if (w_req[~w_gntSel]) begin
                            r_lockCnt <= r_lockCnt + CW'(1);
                        end
                    end else begin
                        r_lockCnt <= CW'(1);
                    end
                end else begin
                    r_owned   <= 1'b0;
                    r_lockCnt <= '0;
                end
            end else begin
                r_owned   <= 1'b0;
                r_lockCnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a behavioural
// arbitration model and a reference copy of the memory contents.
module tb_mem_arbiter;
    localparam int AW       = 9;
    localparam int DW       = 16;
    localparam int LOCK_MAX = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic          reqV   [2];
    logic          weV    [2];
    logic          lockV  [2];
    logic [AW-1:0] addrV  [2];
    logic [DW-1:0] wdataV [2];

    assign bus.req0   = reqV[0];
    assign bus.req1   = reqV[1];
    assign bus.we0    = weV[0];
    assign bus.we1    = weV[1];
    assign bus.lock0  = lockV[0];
    assign bus.lock1  = lockV[1];
    assign bus.addr0  = addrV[0];
    assign bus.addr1  = addrV[1];
    assign bus.wdata0 = wdataV[0];
    assign bus.wdata1 = wdataV[1];

    // Memory array behind the arbiter: synchronous read, one cycle latency.
    logic [DW-1:0] fMem     [512];
    bit            fWritten [512];
    logic [DW-1:0] fRdata = '0;

    assign bus.mem_rdata = fRdata;

    function automatic logic [DW-1:0] initWord(int a);
        if (a == 5) return 16'h1234;
        return 16'(32'h0300 + a * 7);
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                fMem[bus.mem_addr]     <= bus.mem_wdata;
                fWritten[bus.mem_addr] <= 1'b1;
            end else begin
                fRdata <= fWritten[bus.mem_addr] ? fMem[bus.mem_addr] : initWord(int'(bus.mem_addr));
            end
        end
    end

    // Reference model: who last won, who holds a lock and how many grants it has used.
    logic [DW-1:0] refMem [512];
    int mLast;
    int mOwner;
    int mCnt;
    int assertCount = 0;
    int failCount   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pickPort();
        if (mOwner >= 0 && reqV[mOwner] && mCnt < LOCK_MAX) return mOwner;
        if (reqV[0] && reqV[1]) return 1 - mLast;
        if (reqV[0]) return 0;
        if (reqV[1]) return 1;
        return -1;
    endfunction

    task automatic modelUpdate(input int g);
        if (g < 0) begin
            mOwner = -1;
            mCnt   = 0;
        end else begin
            mLast = g;
            if (lockV[g]) begin
                if (mOwner == g) begin
                    if (reqV[1 - g]) mCnt++;
                end else begin
                    mOwner = g;
                    mCnt   = 1;
                end
            end else begin
                mOwner = -1;
                mCnt   = 0;
            end
        end
    endtask

    task automatic modelReset();
        mLast  = 1;
        mOwner = -1;
        mCnt   = 0;
    endtask

    task automatic applyStimulus(input int p, input int r, input int w, input int l,
                                 input int a, input int d);
        reqV[p]   = (r != 0);
        weV[p]    = (w != 0);
        lockV[p]  = (l != 0);
        addrV[p]  = AW'(a);
        wdataV[p] = DW'(d);
    endtask

    // One clock: check combinational grant outputs, then registered read return.
    task automatic checkOutput(output int mg, output int dg);
        logic          expWe;
        logic [AW-1:0] expAddr;
        logic [DW-1:0] expWdata;
        logic [DW-1:0] expData;
        logic          expRv0;
        logic          expRv1;
        #1;
        mg       = pickPort();
        dg       = bus.gnt1 ? 1 : (bus.gnt0 ? 0 : -1);
        expWe    = (mg >= 0) ? weV[mg] : 1'b0;
        expAddr  = (mg >= 0) ? addrV[mg] : '0;
        expWdata = (mg >= 0) ? wdataV[mg] : '0;
        check("gnt0", bus.gnt0, mg == 0);
        check("gnt1", bus.gnt1, mg == 1);
        check("mem_en", bus.mem_en, mg >= 0);
        check("mem_we", bus.mem_we, expWe);
        check("mem_addr", bus.mem_addr, expAddr);
        check("mem_wdata", bus.mem_wdata, expWdata);
        @(posedge clk);
        expRv0  = (mg == 0) && !weV[0];
        expRv1  = (mg == 1) && !weV[1];
        expData = (mg >= 0) ? refMem[addrV[mg]] : '0;
        if (mg >= 0 && weV[mg]) refMem[addrV[mg]] = wdataV[mg];
        modelUpdate(mg);
        #1;
        check("rvalid0", bus.rvalid0, expRv0);
        check("rvalid1", bus.rvalid1, expRv1);
        if (expRv0 || expRv1) check("rdata", bus.rdata, expData);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        check("rst_gnt0", bus.gnt0, 1'b0);
        check("rst_gnt1", bus.gnt1, 1'b0);
        check("rst_mem_en", bus.mem_en, 1'b0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        @(posedge clk);
        #1;
        check("rst_rvalid0", bus.rvalid0, 1'b0);
        check("rst_rvalid1", bus.rvalid1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
    endtask

    initial begin
        int mg;
        int dg;
        int seq [12];
        int wIdx;
        int run;

        for (int i = 0; i < 512; i++) refMem[i] = initWord(i);
        applyStimulus(0, 1, 0, 0, 5, 0);
        applyStimulus(1, 1, 0, 1, 7, 0);
        modelReset();
        @(negedge clk);
        doReset();

        // Single read from port 0
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput(mg, dg);
        check("t1_gnt", dg, 0);
        check("t1_rvalid0", bus.rvalid0, 1'b1);
        check("t1_rvalid1", bus.rvalid1, 1'b0);
        check("t1_rdata", bus.rdata, 16'h1234);
        reqV[0] = 1'b0;
        checkOutput(mg, dg);

        // Both ports reading with no lock alternate from reset
        doReset();
        applyStimulus(0, 1, 0, 0, 3, 0);
        applyStimulus(1, 1, 0, 0, 4, 0);
        for (int i = 0; i < 6; i++) begin
            checkOutput(mg, dg);
            check("t2_alternate", dg, i % 2);
        end
        reqV[0] = 1'b0;
        reqV[1] = 1'b0;
        checkOutput(mg, dg);

        // Loader write immediately read back by the CPU
        applyStimulus(1, 1, 1, 0, 10, 16'hBEEF);
        checkOutput(mg, dg);
        reqV[1] = 1'b0;
        applyStimulus(0, 1, 0, 0, 10, 0);
        checkOutput(mg, dg);
        check("t5_rvalid0", bus.rvalid0, 1'b1);
        check("t5_rdata", bus.rdata, 16'hBEEF);
        reqV[0] = 1'b0;

        // Locked write burst against continuous CPU reads
        applyStimulus(0, 1, 0, 0, 32, 0);
        applyStimulus(1, 1, 1, 1, 256, 16'hA000);
        wIdx = 0;
        for (int i = 0; i < 5; i++) begin
            checkOutput(mg, dg);
            check("t3_burst", dg, (i < 4) ? 1 : 0);
            if (mg == 1) begin
                wIdx++;
                if (wIdx < 4) applyStimulus(1, 1, 1, 1, 256 + wIdx, 16'hA000 + wIdx);
                else reqV[1] = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) check("t3_mem", fMem[256 + i], 16'hA000 + i);
        reqV[0] = 1'b0;

        // Continuous lock by port 1 is cut off after LOCK_MAX grants
        doReset();
        applyStimulus(0, 1, 0, 0, 40, 0);
        applyStimulus(1, 1, 0, 1, 41, 0);
        for (int i = 0; i < 12; i++) begin
            checkOutput(mg, dg);
            seq[i] = dg;
            check("t4_seq", dg, (i == 0 || i == LOCK_MAX + 1) ? 0 : 1);
        end
        run = 0;
        for (int i = 1; i < 12 && seq[i] == 1; i++) run++;
        check("t4_run", run, LOCK_MAX);
        reqV[0] = 1'b0;
        reqV[1] = 1'b0;
        checkOutput(mg, dg);

        // Reset pulse during a granted read drops the pending return
        applyStimulus(0, 1, 0, 0, 5, 0);
        #1;
        check("t6_gnt_pre", bus.gnt0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_gnt_forced", bus.gnt0, 1'b0);
        @(posedge clk);
        #1;
        check("t6_rvalid_rst", bus.rvalid0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        #1;
        check("t6_no_late", bus.rvalid0, 1'b0);
        applyStimulus(1, 1, 0, 0, 9, 0);
        checkOutput(mg, dg);
        check("t6_tie", dg, 0);

        // Randomized traffic with holding requesters and random locks
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!reqV[p] && $urandom_range(0, 3) != 0)
                    applyStimulus(p, 1, $urandom_range(0, 1), $urandom_range(0, 1),
                                  $urandom_range(0, 15), $urandom);
                else if ($urandom_range(0, 3) == 0)
                    lockV[p] = ~lockV[p];
            end
            checkOutput(mg, dg);
            if (mg >= 0 && $urandom_range(0, 2) != 0) reqV[mg] = 1'b0;
            else if (mg >= 0)
                applyStimulus(mg, 1, $urandom_range(0, 1), lockV[mg],
                              $urandom_range(0, 15), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
